// File: rtl/uart_rx_framer_if.sv
// rtl/uart_rx_framer_if.sv - received-frame result bundle between the UART receive framer and its consumer
interface uart_rx_framer_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] p_data;
    logic              data_valid;
    logic              parity_error;
    logic              stop_error;
    logic              busy;

    modport master (
        output p_data,
        output data_valid,
        output parity_error,
        output stop_error,
        output busy
    );

    modport slave (
        input p_data,
        input data_valid,
        input parity_error,
        input stop_error,
        input busy
    );
endinterface

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive deserializer with parity/stop checking
// Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority vote around each bit mid-point.
module uart_rx_framer #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_data,
    input  logic              parity_en,
    input  logic              parity_type,
    input  logic [PWIDTH-1:0] prescale,
    uart_rx_framer_if.master  rx
);
    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t            state, state_nxt;
    logic              s_meta, sync_s;
    logic [PWIDTH-1:0] edge_cnt, edge_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [DWIDTH-1:0] shift_reg, shift_nxt;
    logic [PWIDTH-1:0] presc_q, presc_nxt;
    logic              par_en_q, par_en_nxt;
    logic              par_type_q, par_type_nxt;
    logic              par_err_q, par_err_nxt;
    logic [DWIDTH-1:0] p_data_q, p_data_nxt;
    logic              dv_q, dv_nxt;
    logic              pe_q, pe_nxt;
    logic              se_q, se_nxt;
    logic              bit_val;
    logic [PWIDTH-1:0] sample_at;
    logic              samp, wrap;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s_d1, s_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d1 <= 1'b1;
            s_d2 <= 1'b1;
        end else begin
            s_d1 <= sync_s;
            s_d2 <= s_d1;
        end
    end

    // At half+1 the three taps hold the line at half-1, half and half+1.
    assign bit_val   = (sync_s & s_d1) | (sync_s & s_d2) | (s_d1 & s_d2);
    assign sample_at = (presc_q >> 1) + PWIDTH'(1);
`else
    assign bit_val   = sync_s;
    assign sample_at = presc_q >> 1;
`endif

    assign samp = (edge_cnt == sample_at);
    assign wrap = (edge_cnt == presc_q - PWIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta     <= 1'b1;
            sync_s     <= 1'b1;
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_err_q  <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            s_meta     <= s_data;
            sync_s     <= s_meta;
            state      <= state_nxt;
            edge_cnt   <= edge_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            presc_q    <= presc_nxt;
            par_en_q   <= par_en_nxt;
            par_type_q <= par_type_nxt;
            par_err_q  <= par_err_nxt;
            p_data_q   <= p_data_nxt;
            dv_q       <= dv_nxt;
            pe_q       <= pe_nxt;
            se_q       <= se_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        edge_nxt     = wrap ? '0 : edge_cnt + PWIDTH'(1);
        bit_nxt      = bit_cnt;
        shift_nxt    = shift_reg;
        presc_nxt    = presc_q;
        par_en_nxt   = par_en_q;
        par_type_nxt = par_type_q;
        par_err_nxt  = par_err_q;
        p_data_nxt   = p_data_q;
        dv_nxt       = 1'b0;
        pe_nxt       = 1'b0;
        se_nxt       = 1'b0;
        case (state)
            IDLE: begin
                edge_nxt = '0;
                if (!sync_s) begin
                    state_nxt    = START;
                    presc_nxt    = prescale;
                    par_en_nxt   = parity_en;
                    par_type_nxt = parity_type;
                    par_err_nxt  = 1'b0;
                    bit_nxt      = '0;
                end
            end
            START: begin
                if (samp && bit_val) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (samp) shift_nxt = {bit_val, shift_reg[DWIDTH-1:1]};
                if (wrap) begin
                    if (bit_cnt == BW'(DWIDTH - 1)) begin
                        bit_nxt   = '0;
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (samp) par_err_nxt = (bit_val != ((^shift_reg) ^ par_type_q));
                if (wrap) state_nxt = STOP;
            end
            STOP: begin
                // Leave at the mid-point so a back-to-back start edge is not missed.
                if (samp) begin
                    if (!bit_val) begin
                        se_nxt    = 1'b1;
                        pe_nxt    = par_err_q;
                        state_nxt = WAIT_HIGH;
                    end else begin
                        if (par_err_q) begin
                            pe_nxt = 1'b1;
                        end else begin
                            dv_nxt     = 1'b1;
                            p_data_nxt = shift_reg;
                        end
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                edge_nxt = '0;
                if (sync_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx.p_data       = p_data_q;
    assign rx.data_valid   = dv_q;
    assign rx.parity_error = pe_q;
    assign rx.stop_error   = se_q;
    assign rx.busy         = (state != IDLE);
endmodule
